sequence_detector_moore: RTL and testbench
==========================================

Name: sequence_detector_moore

Overview:
- Moore finite-state machine that detects the serial bit pattern 1011 on a 1-bit input stream, sampling one bit per clock.
- Overlapping matches are detected.
- The output is decoded from the current state only and is high for exactly one cycle per match.
- Standalone leaf block used as a serial pattern monitor.

Parameters:
- None. The pattern 1011 is fixed.

Ports:
- clock  input  1  system clock; all state updates occur on the rising edge.
- reset  input  1  synchronous, active-high reset; one clock, reset sampled on the rising edge of clock.
- sequence_in  input  1  serial data bit, sampled on each rising edge of clock.
- detector_out  output  1  high while the FSM is in the match state; depends on state only, never combinationally on sequence_in.

Behaviour:
- Five states, 3-bit encoding:
  - S_ZERO=000: idle, no prefix matched.
  - S_ONE=001: "1" matched.
  - S_ONEZERO=011: "10" matched.
  - S_ONEZEROONE=010: "101" matched.
  - S_MATCH=110: "1011" matched.
- Reset: if reset=1 at a rising edge, state becomes S_ZERO regardless of sequence_in; detector_out=0 from that edge. Reset has priority over all transitions, including while in S_MATCH.
- Transitions at each rising edge with reset=0 (in=sequence_in):
  - S_ZERO: in=1 -> S_ONE; in=0 -> S_ZERO.
  - S_ONE: in=0 -> S_ONEZERO; in=1 -> S_ONE.
  - S_ONEZERO: in=1 -> S_ONEZEROONE; in=0 -> S_ZERO.
  - S_ONEZEROONE: in=1 -> S_MATCH; in=0 -> S_ONEZERO.
  - S_MATCH: in=1 -> S_ONE; in=0 -> S_ONEZERO (overlap: trailing "1" is reused).
- Unused encodings (100, 101, 111) go to S_ZERO on the next edge with detector_out=0.
- Output: detector_out = (state == S_MATCH). Single state register, output decoded combinationally from it.
- Latency: the final '1' sampled at edge k makes detector_out high from edge k until edge k+1, i.e. one full clock period.
- Back-to-back matches:
  - 1011011 gives two pulses, 3 cycles apart.
  - 1011 followed by 011 gives the second pulse.
  - A run of 1s never matches without an intervening 0.
- X on sequence_in is not supported; the bench always drives 0/1.

Decomposition:
- Package sequence_detector_pkg holds the state enum type (3-bit) and its encodings listed above.
- No sub-module. One sequential block for the state register with synchronous reset, one combinational next-state block, one output decode assign.

Test Plan:
- Reset hold: reset=1 for 3 edges with sequence_in=0 -> state S_ZERO, detector_out=0. Then reset=0 and bits 0,0,0,0,0 -> detector_out stays 0.
- No-match stream: after reset, per edge 0×5, 1,1,0,0, 1×8, 0,0 -> detector_out=0 at every cycle. State trace at the key bits: S_ONE, S_ONE, S_ONEZERO, S_ZERO, S_ONE…, S_ONEZERO, S_ZERO.
- Single match: bits 1,0,1,1 then 0 -> detector_out=1 for exactly one cycle, starting at the edge sampling the 4th bit. Then 0, with state S_ONEZERO.
- Overlap: bits 1,0,1,1,0,1,1 -> two one-cycle pulses, at the edges sampling bit 4 and bit 7.
- Partial/backtrack: bits 1,0,1,0,1,1 -> one pulse at bit 6 (S_ONEZEROONE on 0 goes to S_ONEZERO). Bits 1,0,0,1,1 -> no pulse.
- Reset mid-operation: bits 1,0,1, then reset=1 for one edge with sequence_in=1, then 1 -> no pulse, state S_ONE. Reset asserted while in S_MATCH -> detector_out=0 after that edge.

Source files
------------

// File: rtl/sequence_detector_pkg.sv
// Shared definitions for the 1011 serial pattern detector.
//   state_t        : 3-bit state register type
//   S_* constants  : state encodings; 100, 101 and 111 are unused
package sequence_detector_pkg;

  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] S_ZERO       = 3'b000; // no prefix matched
  localparam logic [2:0] S_ONE        = 3'b001; // "1"
  localparam logic [2:0] S_ONEZERO    = 3'b011; // "10"
  localparam logic [2:0] S_ONEZEROONE = 3'b010; // "101"
  localparam logic [2:0] S_MATCH      = 3'b110; // "1011"

endpackage : sequence_detector_pkg

// File: rtl/sequence_detector_moore.sv
// Moore detector for the overlapping serial pattern 1011.
// Ports:
//   clock        : system clock, rising edge active
//   reset        : synchronous active-high reset
//   sequence_in  : serial data bit, one per clock
//   detector_out : high for one cycle while the FSM sits in the match state
module sequence_detector_moore
  import sequence_detector_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic sequence_in,
  output logic detector_out
);

  state_t state;
  state_t state_next;

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_ZERO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; S_MATCH reuses its trailing "1" so overlaps are caught.
  always_comb begin
    state_next = S_ZERO;
    case (state)
      S_ZERO:       state_next = sequence_in ? S_ONE        : S_ZERO;
      S_ONE:        state_next = sequence_in ? S_ONE        : S_ONEZERO;
      S_ONEZERO:    state_next = sequence_in ? S_ONEZEROONE : S_ZERO;
      S_ONEZEROONE: state_next = sequence_in ? S_MATCH      : S_ONEZERO;
      S_MATCH:      state_next = sequence_in ? S_ONE        : S_ONEZERO;
      default:      state_next = S_ZERO;
    endcase
  end

  // Moore output: decoded from state only.
  assign detector_out = (state == S_MATCH);

endmodule : sequence_detector_moore

// File: tb/tb_sequence_detector_moore.sv
// Self-checking bench for sequence_detector_moore. Expected output and state
// come from a bit-history model (longest suffix of the stream since reset that
// is a prefix of 1011), pushed to a scoreboard when a bit is driven and
// compared one edge later.
module tb_sequence_detector_moore;
  import sequence_detector_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sequence_in = 1'b0;
  logic detector_out;

  typedef struct packed {
    logic       out;
    logic [2:0] st;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [3:0]  hist   = 4'b0000;
  int unsigned nbits  = 0;
  int unsigned pulses = 0;

  sequence_detector_moore dut (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .detector_out (detector_out)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Longest suffix of the post-reset history that is a prefix of 1011.
  function automatic logic [2:0] model_state();
    if (nbits >= 4 && hist == 4'b1011)          return S_MATCH;
    if (nbits >= 3 && hist[2:0] == 3'b101)      return S_ONEZEROONE;
    if (nbits >= 2 && hist[1:0] == 2'b10)       return S_ONEZERO;
    if (nbits >= 1 && hist[0] == 1'b1)          return S_ONE;
    return S_ZERO;
  endfunction

  // Drive one bit (or a reset cycle), predict, then check after the edge.
  task automatic step(input logic r, input logic b, input string tag);
    exp_t e;
    @(negedge clock);
    reset       = r;
    sequence_in = b;
    if (r) begin
      hist  = 4'b0000;
      nbits = 0;
    end else begin
      hist = {hist[2:0], b};
      if (nbits < 4) nbits++;
    end
    e.out = (nbits >= 4) && (hist == 4'b1011);
    e.st  = model_state();
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check_val({tag, "_out"}, 3'(detector_out), 3'(e.out));
    check_val({tag, "_state"}, dut.state, e.st);
    if (detector_out === 1'b1) pulses++;
  endtask

  task automatic run_bits(input string tag, input logic [31:0] bits, input int unsigned n);
    for (int i = int'(n) - 1; i >= 0; i--) step(1'b0, bits[i], tag);
  endtask

  initial begin
    int unsigned p0;

    // Reset hold, then idle zeros.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "reset_hold");
    run_bits("idle_zeros", 32'b00000, 5);

    // No-match stream: 0x5, 1100, 1x8, 00.
    p0 = pulses;
    run_bits("nomatch", 32'b00000_1100_11111111_00, 19);
    check_val("nomatch_pulses", 3'(pulses - p0), 3'd0);

    // Single match then trailing zeros.
    step(1'b1, 1'b0, "reset");
    p0 = pulses;
    run_bits("single", 32'b1011_0, 5);
    check_val("single_pulses", 3'(pulses - p0), 3'd1);
    step(1'b0, 1'b0, "single_tail");

    // Overlap: two pulses.
    step(1'b1, 1'b0, "reset");
    p0 = pulses;
    run_bits("overlap", 32'b1011011, 7);
    check_val("overlap_pulses", 3'(pulses - p0), 3'd2);

    // Backtrack from "101" on 0, then a non-match.
    step(1'b1, 1'b0, "reset");
    p0 = pulses;
    run_bits("backtrack", 32'b101011, 6);
    check_val("backtrack_pulses", 3'(pulses - p0), 3'd1);
    step(1'b1, 1'b0, "reset");
    p0 = pulses;
    run_bits("no_pulse", 32'b10011, 5);
    check_val("no_pulse_pulses", 3'(pulses - p0), 3'd0);

    // Reset mid-operation with sequence_in=1, then a 1.
    step(1'b1, 1'b0, "reset");
    p0 = pulses;
    run_bits("mid_pre", 32'b101, 3);
    step(1'b1, 1'b1, "mid_reset");
    step(1'b0, 1'b1, "mid_post");
    check_val("mid_state", dut.state, S_ONE);
    check_val("mid_pulses", 3'(pulses - p0), 3'd0);

    // Reset while in S_MATCH.
    run_bits("pre_match", 32'b011, 3);
    check_val("in_match_out", 3'(detector_out), 3'd1);
    step(1'b1, 1'b1, "reset_in_match");

    // Random stream.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 63) == 0) step(1'b1, 1'($urandom_range(0, 1)), "rand_reset");
      else                            step(1'b0, 1'($urandom_range(0, 1)), "rand");
    end

    check_val("sb_empty", 3'(sb_q.size()), 3'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sequence_detector_moore
